// File: rtl/cache_victim_selector.sv
// ---------------------------------------------------------------------------
// cache_victim_selector
//
// Chooses which way of a 4-way set to fill on a cache miss. If the missing
// set has an invalid way, the lowest-index invalid way is returned and no
// eviction is needed. Otherwise the tree-PLRU victim of that set is returned.
// Each set keeps 3 PLRU bits {b2,b1,b0}:
//   b0 = root (0 points at the way 0/1 side);
//   b1 = choice within ways 0/1;
//   b2 = choice within ways 2/3.
// The PLRU bits are refreshed by cache hits (touch) and by every accepted fill.
//
// Ports
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   req_v_i        miss request valid
//   req_ready_o    request can be accepted this cycle
//   req_set_i      set index of the miss
//   valid_bits_i   way valid bits of the missing set (bit n = way n)
//   res_v_o        victim response valid (one cycle after acceptance)
//   res_ready_i    consumer accepts the response
//   res_way_o      selected victim way
//   res_invalid_o  1 when the chosen way was invalid (no eviction needed)
//   touch_v_i      hit notification, one-cycle pulse
//   touch_set_i    set index of the hit
//   touch_way_i    way of the hit
// ---------------------------------------------------------------------------
module cache_victim_selector #(
    parameter  int sets_p     = 16,
    localparam int lg_sets_lp = $clog2(sets_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_v_i,
    output logic                  req_ready_o,
    input  logic [lg_sets_lp-1:0] req_set_i,
    input  logic [3:0]            valid_bits_i,
    output logic                  res_v_o,
    input  logic                  res_ready_i,
    output logic [1:0]            res_way_o,
    output logic                  res_invalid_o,
    input  logic                  touch_v_i,
    input  logic [lg_sets_lp-1:0] touch_set_i,
    input  logic [1:0]            touch_way_i
);

    // Marks a way as most recently used: the root and the way's own pair bit
    // are flipped to point away from it. The other pair's bit is untouched.
    function automatic logic [2:0] plruUpdate(input logic [2:0] state,
                                              input logic [1:0] way);
        logic [2:0] nextState;
        nextState    = state;
        nextState[0] = ~way[1];
        if (way[1]) begin
            nextState[2] = ~way[0];
        end else begin
            nextState[1] = ~way[0];
        end
        return nextState;
    endfunction

    logic [2:0] plruState_q [sets_p];
    logic [2:0] plruState_d [sets_p];

    logic       resValid_q,   resValid_d;
    logic [1:0] resWay_q,     resWay_d;
    logic       resInvalid_q, resInvalid_d;

    logic       reqAccept;
    logic [2:0] reqPlru;
    logic [1:0] selWay;
    logic       selInvalid;
    logic [2:0] fillBase;

    // A new request may enter whenever the output slot is empty or is being
    // drained this very cycle.
    assign req_ready_o = ~resValid_q | res_ready_i;
    assign reqAccept   = req_v_i & req_ready_o;
    assign reqPlru     = plruState_q[req_set_i];

    // Victim selection uses the registered (pre-touch) PLRU state of the
    // missing set; an invalid way always takes priority over eviction.
    always_comb begin
        selWay     = 2'd0;
        selInvalid = 1'b0;
        if (!valid_bits_i[0]) begin
            selWay     = 2'd0;
            selInvalid = 1'b1;
        end else if (!valid_bits_i[1]) begin
            selWay     = 2'd1;
            selInvalid = 1'b1;
        end else if (!valid_bits_i[2]) begin
            selWay     = 2'd2;
            selInvalid = 1'b1;
        end else if (!valid_bits_i[3]) begin
            selWay     = 2'd3;
            selInvalid = 1'b1;
        end else if (!reqPlru[0]) begin
            selWay = {1'b0, reqPlru[1]};
        end else begin
            selWay = {1'b1, reqPlru[2]};
        end
    end

    // When a hit and a fill land on the same set in one cycle, the fill update
    // is layered on top of the touched state so the fill wins on shared bits.
    always_comb begin
        fillBase = reqPlru;
        if (touch_v_i && (touch_set_i == req_set_i)) begin
            fillBase = plruUpdate(reqPlru, touch_way_i);
        end
    end

    // Next PLRU state: touches are always taken; a fill only on acceptance.
    always_comb begin
        plruState_d = plruState_q;
        if (touch_v_i) begin
            plruState_d[touch_set_i] = plruUpdate(plruState_q[touch_set_i], touch_way_i);
        end
        if (reqAccept) begin
            plruState_d[req_set_i] = plruUpdate(fillBase, selWay);
        end
    end

    // Response slot: loads on acceptance, holds while stalled, empties once
    // the consumer takes it and nothing new arrives.
    always_comb begin
        resValid_d   = resValid_q;
        resWay_d     = resWay_q;
        resInvalid_d = resInvalid_q;
        if (reqAccept) begin
            resValid_d   = 1'b1;
            resWay_d     = selWay;
            resInvalid_d = selInvalid;
        end else if (res_ready_i) begin
            resValid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < sets_p; i++) begin
                plruState_q[i] <= 3'b000;
            end
            resValid_q   <= 1'b0;
            resWay_q     <= 2'd0;
            resInvalid_q <= 1'b0;
        end else begin
            plruState_q  <= plruState_d;
            resValid_q   <= resValid_d;
            resWay_q     <= resWay_d;
            resInvalid_q <= resInvalid_d;
        end
    end

    assign res_v_o       = resValid_q;
    assign res_way_o     = resWay_q;
    assign res_invalid_o = resInvalid_q;

endmodule
